uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial transmitter for the UART link; it is the transmit-side counterpart to the UART receiver.
- Accepts one byte per handshake from the host logic.
- Sends the byte as an 8N1 frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Timing comes from an internal baud divider.
- Sits between the control FSM of the lock design and the TX pin of the board.

Parameters:
BAUD, 1250, clock cycles per bit (default gives 9600 baud at 12 MHz); legal range 2..65535.

Ports:
clk    input   1  system clock, all logic on rising edge
rstn   input   1  synchronous active-low reset
start  input   1  transmit request; accepted when start=1 and ready=1 at a clk edge
data   input   8  byte to send; sampled only at the accepting edge
tx     output  1  serial line, registered, idle high
ready  output  1  1 = idle and able to accept a byte
done   output  1  single-cycle pulse when a frame's stop bit completes

Behaviour:
Reset (rstn=0 at a clk edge):
- tx=1, ready=1, done=0.
- State IDLE; bit counter and baud counter cleared.
- Reset mid-frame aborts the frame. tx returns to 1 at that edge, and no done pulse is produced.

State machine IDLE -> START -> DATA -> STOP -> IDLE:
- IDLE: tx=1, ready=1. On start=1 at edge k:
  - latch data into the shift register;
  - clear the baud counter;
  - state<=START, ready<=0, tx<=0.
- START: tx=0 for exactly BAUD cycles, i.e. after edge k through edge k+BAUD. Then DATA, bit index 0.
- DATA: tx=data[i] for BAUD cycles each, i=0..7, LSB first.
  - The shift register shifts right once per bit period.
  - After bit 7's period, go to STOP.
- STOP: tx=1 for BAUD cycles. At the final edge:
  - state<=IDLE, ready<=1;
  - done<=1 for exactly one cycle.

Baud divider:
- Counter 0..BAUD-1, enabled only outside IDLE.
- Terminal count marks the end of a bit period.
- Counter width is ceil(log2(BAUD)) bits, minimum 1.
- Counter cleared in IDLE and on reset.

Frame timing:
- Total frame = 10*BAUD cycles from the accepting edge k.
- ready=0 from edge k+1 through edge k+10*BAUD−1 (i.e. ready is low for 10*BAUD cycles), and returns to 1 after edge k+10*BAUD.
- The bit counter is 4 bits and counts the 8 data bits; no wrap beyond 7 in use.

Handshake and boundary cases:
- start while ready=0: ignored; no queueing; no effect on the frame in flight.
- data changes while busy: no effect; the latched copy is sent.
- start held high continuously: a new frame is accepted at the first edge where ready=1.
  - Back-to-back frames therefore have a stop bit of BAUD+1 cycles.
  - That is the minimum inter-frame spacing.
- start asserted in the same cycle as rstn=0: reset wins; the frame is not accepted.
- done and ready rise at the same edge. done clears on the next edge regardless of start.
- tx is driven only from a register; it never glitches between edges.

Test Plan:
1. Reset with rstn=0 for 3 cycles, then release; leave start=0 for 20 cycles -> tx=1, ready=1 and done=0 throughout.
2. BAUD=4; send data=0x55 at edge k:
   - tx low for cycles k+1..k+4;
   - then bits 1,0,1,0,1,0,1,0, 4 cycles each;
   - stop high 4 cycles;
   - ready=1 and done pulse one cycle after edge k+40.
3. BAUD=4; send data=0xA3 with start held high continuously:
   - second frame's start bit begins one cycle after ready rises;
   - stop bit measures 5 cycles;
   - line sampling mid-bit recovers 0xA3 twice.
4. BAUD=4; pulse start with data=0xFF at cycle 10 of an in-flight 0x00 frame -> frame remains 0x00, ready stays 0, and only one done pulse occurs.
5. BAUD=4; assert rstn=0 during data bit 3 of 0x0F -> tx=1 and ready=1 on the next cycle, no done pulse; a following start with 0x81 transmits a correct full frame.
6. Loopback: connect tx to the UART receiver with BAUD=1250; send 0x00, 0xFF, 0x5A -> receiver reports those three bytes in order, each within 10*1250+a few cycles of acceptance.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with internal baud divider.
// One byte per start/ready handshake; done pulses at end of stop bit.
module uart_tx #(
  parameter int BAUD = 1250
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int CW = (BAUD > 2) ? $clog2(BAUD) : 1;
  localparam logic [CW-1:0] TC = CW'(BAUD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          tx_q, tx_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;
  logic          accept;
  logic          tick;

  assign accept = rdy_q & start;
  assign tick   = (state_q != IDLE) && (cnt_q == TC);

  assign tx    = tx_q;
  assign ready = rdy_q;
  assign done  = done_q;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance one phase per terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick && bit_q == 4'd7) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for divider, shifter and the registered outputs.
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    shf_d  = shf_q;
    tx_d   = tx_q;
    rdy_d  = rdy_q;
    done_d = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
        bit_d = 4'd0;
        if (accept) begin
          shf_d = data;
          tx_d  = 1'b0;
          rdy_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          tx_d  = shf_q[0];
          bit_d = 4'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shf_d = {1'b0, shf_q[7:1]};
          bit_d = bit_q + 4'd1;
          tx_d  = (bit_q == 4'd7) ? 1'b1 : shf_q[1];
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          rdy_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      default: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
      end
    endcase
  end

  // Datapath and output registers; tx only ever comes from a flop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      bit_q  <= 4'd0;
      shf_q  <= 8'd0;
      tx_q   <= 1'b1;
      rdy_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      shf_q  <= shf_d;
      tx_q   <= tx_d;
      rdy_q  <= rdy_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx frame timing and handshake.
// A BAUD=4 instance covers timing; a BAUD=1250 instance feeds a line receiver.
module tb_uart_tx;

  localparam int B  = 4;
  localparam int BL = 1250;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] data;
  logic       tx, ready, done;
  logic       start_l;
  logic [7:0] data_l;
  logic       tx_l, ready_l, done_l;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.BAUD(B)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .data  (data),
    .tx    (tx),
    .ready (ready),
    .done  (done)
  );

  uart_tx #(.BAUD(BL)) dut_l (
    .clk   (clk),
    .rstn  (rstn),
    .start (start_l),
    .data  (data_l),
    .tx    (tx_l),
    .ready (ready_l),
    .done  (done_l)
  );

  // line receiver for the loopback instance
  int         cyc = 0;
  int         rs = 0, rc = 0, bi = 0, rx_n = 0;
  logic [7:0] sh = 8'd0;
  logic [7:0] rx_mem [0:7];
  int         rx_cyc [0:7];

  always @(negedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (rs)
      0: if (tx_l == 1'b0) begin
        rs <= 1;
        rc <= 0;
      end
      1: if (rc == BL / 2 - 1) begin
        rc <= 0;
        bi <= 0;
        rs <= (tx_l == 1'b0) ? 2 : 0;
      end else rc <= rc + 1;
      2: if (rc == BL - 1) begin
        rc <= 0;
        sh <= {tx_l, sh[7:1]};
        bi <= bi + 1;
        if (bi == 7) rs <= 3;
      end else rc <= rc + 1;
      3: if (rc == BL - 1) begin
        rc <= 0;
        rs <= 0;
        if (tx_l && rx_n < 8) begin
          rx_mem[rx_n] <= sh;
          rx_cyc[rx_n] <= cyc;
          rx_n <= rx_n + 1;
        end
      end else rc <= rc + 1;
      default: rs <= 0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; returns just after edge k+10*B.
  task automatic frame(input logic [7:0] d, input int inj);
    logic [9:0] fr;
    logic [7:0] rec;
    fr  = {1'b1, d, 1'b0};
    rec = 8'd0;
    for (int j = 0; j < 10 * B; j++) begin
      chk("tx_bit", tx, fr[j / B]);
      chk("ready_busy", ready, 1'b0);
      chk("done_busy", done, 1'b0);
      if (j % B == B / 2 && j / B >= 1 && j / B <= 8) rec[j / B - 1] = tx;
      if (inj >= 0 && j == inj) begin
        start = 1'b1;
        data  = 8'hFF;
      end else if (inj >= 0 && j == inj + 1) begin
        start = 1'b0;
      end
      cyc1();
    end
    chk("mid_sample_byte", rec, d);
    chk("ready_end", ready, 1'b1);
    chk("done_pulse", done, 1'b1);
    chk("tx_end", tx, 1'b1);
  endtask

  logic [7:0] lb [0:2];
  int         n;
  int         acc;
  int         lat;

  initial begin
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h5A;
    rstn    = 1'b0;
    start   = 1'b0;
    data    = 8'h00;
    start_l = 1'b0;
    data_l  = 8'h00;

    // reset and idle
    repeat (3) cyc1();
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_tx_l", tx_l, 1'b1);
    chk("rst_ready_l", ready_l, 1'b1);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc1();
      chk("idle_tx", tx, 1'b1);
      chk("idle_ready", ready, 1'b1);
      chk("idle_done", done, 1'b0);
    end

    // single frame 0x55
    data  = 8'h55;
    start = 1'b1;
    cyc1();
    start = 1'b0;
    frame(8'h55, -1);
    cyc1();
    chk("done_clear", done, 1'b0);
    chk("ready_hold", ready, 1'b1);

    // back-to-back 0xA3 with start held
    data  = 8'hA3;
    start = 1'b1;
    cyc1();
    frame(8'hA3, -1);
    cyc1();
    start = 1'b0;
    data  = 8'h00;
    frame(8'hA3, -1);
    cyc1();
    chk("b2b_done_clear", done, 1'b0);
    chk("b2b_ready", ready, 1'b1);

    // start pulse while busy is ignored
    data  = 8'h00;
    start = 1'b1;
    cyc1();
    start = 1'b0;
    frame(8'h00, 10);
    for (int i = 0; i < 6; i++) begin
      cyc1();
      chk("ign_done", done, 1'b0);
      chk("ign_ready", ready, 1'b1);
      chk("ign_tx", tx, 1'b1);
    end

    // reset during data bit 3 of 0x0F
    data  = 8'h0F;
    start = 1'b1;
    cyc1();
    start = 1'b0;
    for (int j = 0; j < 17; j++) cyc1();
    chk("bit3_tx", tx, 1'b1);
    chk("bit3_ready", ready, 1'b0);
    rstn = 1'b0;
    cyc1();
    chk("abort_tx", tx, 1'b1);
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < 8 * B; i++) begin
      cyc1();
      chk("post_abort_done", done, 1'b0);
      chk("post_abort_tx", tx, 1'b1);
    end

    // start in the same cycle as reset
    rstn  = 1'b0;
    start = 1'b1;
    data  = 8'hC3;
    cyc1();
    rstn  = 1'b1;
    start = 1'b0;
    chk("rst_start_ready", ready, 1'b1);
    chk("rst_start_tx", tx, 1'b1);
    cyc1();
    chk("rst_start_ready2", ready, 1'b1);
    chk("rst_start_tx2", tx, 1'b1);

    // recovery frame 0x81
    data  = 8'h81;
    start = 1'b1;
    cyc1();
    start = 1'b0;
    frame(8'h81, -1);
    cyc1();
    chk("rec_done_clear", done, 1'b0);

    // loopback at BAUD=1250
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!ready_l && n < 20 * BL) begin
        cyc1();
        n++;
      end
      chk("lb_ready", ready_l, 1'b1);
      data_l  = lb[i];
      start_l = 1'b1;
      cyc1();
      start_l = 1'b0;
      acc = cyc;
      n = 0;
      while (rx_n <= i && n < 11 * BL) begin
        cyc1();
        n++;
      end
      chk("lb_count", rx_n, i + 1);
      chk("lb_byte", rx_mem[i], lb[i]);
      lat = rx_cyc[i] - acc;
      chk("lb_latency", (lat >= 9 * BL) && (lat <= 10 * BL + 4), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
